// File: rtl/armleocpu_mem_1rw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : armleocpu_mem_1rw_arbiter_pkg
//  Purpose  : Shared defines for the single-port memory arbiter. Holds only
//             the arbiter state encoding (clear sweep / normal operation).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package armleocpu_mem_1rw_arbiter_pkg;

    localparam int c_STATE_W = 1;

    // INIT: memory clear sweep in progress, RUN: requests are arbitrated
    localparam logic [c_STATE_W-1:0] c_STATE_INIT = 1'b0;
    localparam logic [c_STATE_W-1:0] c_STATE_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/armleocpu_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : armleocpu_rr_arb2
//  Purpose  : Two-way round-robin grant. A lone valid requester always wins;
//             under contention the requester named by pointer wins.
//  Ports    : valid[1:0]  - request lines
//             pointer     - requester that wins on contention
//             grant[1:0]  - one-hot grant (all zero when nothing is valid)
//  Revision : 1.0 - initial release
// ============================================================================
module armleocpu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/armleocpu_mem_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : armleocpu_mem_1rw_arbiter
//  Purpose  : Shares one single-port (1RW) memory between two requesters.
//             After reset the whole memory is swept to zero, then accesses
//             are granted round-robin, one per cycle, with read data
//             returned one cycle after acceptance.
//  Ports    : clk, rst_n (async, active low)
//             reqN_valid/write/address/writedata - requester N operation
//             reqN_ready  - grant this cycle
//             reqN_rvalid/readdata - read response for requester N
//             mem_address/read/write/writedata, mem_readdata - memory side
//             init_done   - clear sweep finished
//  Revision : 1.0 - initial release
// ============================================================================
module armleocpu_mem_1rw_arbiter
    import armleocpu_mem_1rw_arbiter_pkg::*;
#(
    parameter int ELEMENTS_W = 7,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [ELEMENTS_W-1:0] req0_address,
    input  logic [WIDTH-1:0]      req0_writedata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [WIDTH-1:0]      req0_readdata,

    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [ELEMENTS_W-1:0] req1_address,
    input  logic [WIDTH-1:0]      req1_writedata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [WIDTH-1:0]      req1_readdata,

    output logic [ELEMENTS_W-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WIDTH-1:0]      mem_writedata,
    input  logic [WIDTH-1:0]      mem_readdata,

    output logic                  init_done
);

    localparam logic [ELEMENTS_W-1:0] c_LAST_ADDR = {ELEMENTS_W{1'b1}};
    localparam logic [ELEMENTS_W-1:0] c_ONE       = {{(ELEMENTS_W-1){1'b0}}, 1'b1};

    logic [c_STATE_W-1:0]  r_state;
    logic [c_STATE_W-1:0]  w_state_next;
    logic [ELEMENTS_W-1:0] r_counter;
    logic [ELEMENTS_W-1:0] w_counter_next;
    logic                  r_pointer;
    logic                  w_pointer_next;
    logic [1:0]            r_rvalid;
    logic [1:0]            w_rvalid_next;
    logic [1:0]            w_valid;
    logic [1:0]            w_grant;

    assign w_valid = {req1_valid, req0_valid};

    armleocpu_rr_arb2 u_rr_arb2 (
        .valid   (w_valid),
        .pointer (r_pointer),
        .grant   (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_STATE_INIT;
            r_counter <= '0;
            r_pointer <= 1'b0;
            r_rvalid  <= 2'b00;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
            r_pointer <= w_pointer_next;
            r_rvalid  <= w_rvalid_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_pointer_next = r_pointer;
        w_rvalid_next  = 2'b00;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;

        case (r_state)
            c_STATE_INIT: begin
                // Zero one entry per cycle; the counter wraps back to 0 on
                // the last entry, so it is already clean for a later sweep.
                mem_write      = 1'b1;
                mem_address    = r_counter;
                w_counter_next = r_counter + c_ONE;
                if (r_counter == c_LAST_ADDR)
                    w_state_next = c_STATE_RUN;
            end
            c_STATE_RUN: begin
                req0_ready = w_grant[0];
                req1_ready = w_grant[1];
                if (w_grant[1]) begin
                    mem_address   = req1_address;
                    mem_writedata = req1_writedata;
                    mem_write     = req1_write;
                    mem_read      = ~req1_write;
                end else if (w_grant[0]) begin
                    mem_address   = req0_address;
                    mem_writedata = req0_writedata;
                    mem_write     = req0_write;
                    mem_read      = ~req0_write;
                end
                w_rvalid_next = {w_grant[1] & ~req1_write, w_grant[0] & ~req0_write};
                // Contention always produces a grant to the pointed-at
                // requester, so handing priority over is a simple toggle.
                if (&w_valid)
                    w_pointer_next = ~r_pointer;
            end
            default: w_state_next = c_STATE_INIT;
        endcase
    end

    assign init_done     = (r_state == c_STATE_RUN);
    assign req0_rvalid   = r_rvalid[0];
    assign req1_rvalid   = r_rvalid[1];
    assign req0_readdata = mem_readdata;
    assign req1_readdata = mem_readdata;

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_mem_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_armleocpu_mem_1rw_arbiter
//  Purpose  : Self-checking bench for armleocpu_mem_1rw_arbiter with an
//             attached 1-cycle-latency memory model (ELEMENTS_W=3, WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_mem_1rw_arbiter;

    localparam int ELEMENTS_W = 3;
    localparam int WIDTH      = 32;
    localparam int ELEMENTS   = 1 << ELEMENTS_W;

    logic                  clk;
    logic                  rst_n;
    logic                  req0_valid, req0_write, req0_ready, req0_rvalid;
    logic [ELEMENTS_W-1:0] req0_address;
    logic [WIDTH-1:0]      req0_writedata, req0_readdata;
    logic                  req1_valid, req1_write, req1_ready, req1_rvalid;
    logic [ELEMENTS_W-1:0] req1_address;
    logic [WIDTH-1:0]      req1_writedata, req1_readdata;
    logic [ELEMENTS_W-1:0] mem_address;
    logic                  mem_read, mem_write;
    logic [WIDTH-1:0]      mem_writedata, mem_readdata;
    logic                  init_done;

    int n_checks = 0;
    int n_errors = 0;

    armleocpu_mem_1rw_arbiter #(.ELEMENTS_W(ELEMENTS_W), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_address(req0_address),
        .req0_writedata(req0_writedata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_readdata(req0_readdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_address(req1_address),
        .req1_writedata(req1_writedata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_readdata(req1_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered read, garbage-filled while reset is held so
    // that an incomplete clear sweep becomes visible.
    logic [WIDTH-1:0] mem_model [ELEMENTS];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ELEMENTS; i++) mem_model[i] <= 32'hA5A5_0000 | i;
        end else begin
            if (mem_write) mem_model[mem_address] <= mem_writedata;
            if (mem_read)  mem_readdata <= mem_model[mem_address];
        end
    end

    // Reference model state
    int               m_cnt;
    bit               m_done;
    int               m_ptr;
    bit [1:0]         m_rv;
    logic [WIDTH-1:0] m_rd [2];
    logic [WIDTH-1:0] shadow [ELEMENTS];

    typedef struct {
        bit v0; bit w0; logic [2:0] a0; logic [31:0] d0;
        bit v1; bit w1; logic [2:0] a1; logic [31:0] d1;
        bit er0; bit er1; bit ev0; bit ev1; logic [31:0] ed0; logic [31:0] ed1;
    } vec_t;
    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input bit w0, input logic [2:0] a0, input logic [31:0] d0,
                         input bit v1, input bit w1, input logic [2:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_write = w0; req0_address = a0; req0_writedata = d0;
        req1_valid = v1; req1_write = w1; req1_address = a1; req1_writedata = d1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_done = 0; m_ptr = 0; m_rv = 2'b00;
    endtask

    // Winner of the current inputs: -1 none, else requester index.
    function automatic int grant_of();
        if (!m_done || (!req0_valid && !req1_valid)) return -1;
        if (req0_valid && req1_valid) return m_ptr;
        return req0_valid ? 0 : 1;
    endfunction

    task automatic check_model();
        int g;
        bit ew;
        g = grant_of();
        chk("init_done", init_done, m_done);
        if (!m_done) begin
            chk("init_ready0", req0_ready, 0);
            chk("init_ready1", req1_ready, 0);
            chk("init_mem_write", mem_write, 1);
            chk("init_mem_read", mem_read, 0);
            chk("init_mem_address", mem_address, 32'(m_cnt));
            chk("init_mem_writedata", mem_writedata, 0);
        end else begin
            chk("ready0", req0_ready, g == 0);
            chk("ready1", req1_ready, g == 1);
            ew = (g == 0) ? req0_write : (g == 1) ? req1_write : 1'b0;
            chk("mem_write", mem_write, (g >= 0) && ew);
            chk("mem_read", mem_read, (g >= 0) && !ew);
            chk("mem_address", mem_address, (g == 0) ? req0_address : (g == 1) ? req1_address : 3'd0);
            chk("mem_writedata", mem_writedata, (g == 0) ? req0_writedata : (g == 1) ? req1_writedata : 32'd0);
        end
        chk("rvalid0", req0_rvalid, m_rv[0]);
        chk("rvalid1", req1_rvalid, m_rv[1]);
        if (m_rv[0]) chk("readdata0", req0_readdata, m_rd[0]);
        if (m_rv[1]) chk("readdata1", req1_readdata, m_rd[1]);
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        int g;
        logic [2:0] a;
        g = grant_of();
        @(posedge clk);
        m_rv = 2'b00;
        if (!m_done) begin
            shadow[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == ELEMENTS) m_done = 1;
        end else begin
            if (g >= 0) begin
                a = (g == 0) ? req0_address : req1_address;
                if ((g == 0) ? req0_write : req1_write)
                    shadow[a] = (g == 0) ? req0_writedata : req1_writedata;
                else begin
                    m_rv[g] = 1'b1;
                    m_rd[g] = shadow[a];
                end
            end
            if (req0_valid && req1_valid) m_ptr = 1 - m_ptr;
        end
        @(negedge clk);
    endtask

    task automatic random_step(input bit both_valid);
        drive(both_valid | 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom,
              both_valid | 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom);
        #1;
        check_model();
        tick();
    endtask

    initial begin
        vecs[0]  = '{1,1,5,32'hDEADBEEF, 0,0,0,0, 1,0, 0,0, 0,0};
        vecs[1]  = '{1,0,5,0,            0,0,0,0, 1,0, 0,0, 0,0};
        vecs[2]  = '{0,0,0,0,            0,0,0,0, 0,0, 1,0, 32'hDEADBEEF,0};
        vecs[3]  = '{1,0,1,0,            1,0,2,0, 1,0, 0,0, 0,0};
        vecs[4]  = '{1,0,1,0,            1,0,2,0, 0,1, 1,0, 0,0};
        vecs[5]  = '{1,0,1,0,            1,0,2,0, 1,0, 0,1, 0,0};
        vecs[6]  = '{1,0,1,0,            1,0,2,0, 0,1, 1,0, 0,0};
        vecs[7]  = '{1,0,1,0,            1,0,2,0, 1,0, 0,1, 0,0};
        vecs[8]  = '{0,0,0,0,            1,0,5,0, 0,1, 1,0, 0,0};
        vecs[9]  = '{0,0,0,0,            1,0,5,0, 0,1, 0,1, 0,32'hDEADBEEF};
        vecs[10] = '{0,0,0,0,            1,0,5,0, 0,1, 0,1, 0,32'hDEADBEEF};
        vecs[11] = '{0,0,0,0,            1,0,5,0, 0,1, 0,1, 0,32'hDEADBEEF};
        vecs[12] = '{1,0,1,0,            1,0,5,0, 0,1, 0,1, 0,32'hDEADBEEF};
        vecs[13] = '{0,0,0,0,            0,0,0,0, 0,0, 0,1, 0,32'hDEADBEEF};
        vecs[14] = '{0,0,0,0,            0,0,0,0, 0,0, 0,0, 0,0};

        rst_n = 1'b0;
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        chk("reset_init_done", init_done, 0);
        chk("reset_rvalid0", req0_rvalid, 0);
        chk("reset_rvalid1", req1_rvalid, 0);
        rst_n = 1'b1;

        // Clear sweep with both requesters asking the whole time
        for (int i = 0; i < ELEMENTS; i++) random_step(1'b1);

        // Directed table: write/read-back, alternation, single requester, unwritten reads
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].er0);
            chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].er1);
            chk($sformatf("vec%0d_rvalid0", i), req0_rvalid, vecs[i].ev0);
            chk($sformatf("vec%0d_rvalid1", i), req1_rvalid, vecs[i].ev1);
            if (vecs[i].ev0) chk($sformatf("vec%0d_readdata0", i), req0_readdata, vecs[i].ed0);
            if (vecs[i].ev1) chk($sformatf("vec%0d_readdata1", i), req1_readdata, vecs[i].ed1);
            tick();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) random_step(1'b0);

        // Reset while a read is in flight
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        #1;
        check_model();
        @(posedge clk);
        #2;
        chk("midrun_rvalid0_before_reset", req0_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_rvalid0", req0_rvalid, 0);
        chk("midrun_reset_init_done", init_done, 0);
        chk("midrun_reset_ready0", req0_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ELEMENTS; i++) random_step(1'b1);
        for (int i = 0; i < 40; i++) random_step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/armleocpu_mem_1rw_arbiter.md
ARMLEOCPU_MEM_1RW_ARBITER -- requirements
Module: armleocpu_mem_1rw_arbiter

Interface
REQ-001 SHALL have parameter ELEMENTS_W, default 7, memory address width (ELEMENTS = 2**ELEMENTS_W).
REQ-002 SHALL have parameter WIDTH, default 32, data width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_write  input  1  1 = write, 0 = read.
REQ-008 reqN_address  input  ELEMENTS_W  target entry.
REQ-009 reqN_writedata  input  WIDTH  write data.
REQ-010 reqN_ready  output  1  operation accepted this cycle (grant).
REQ-011 reqN_rvalid  output  1  read data for requester N valid this cycle.
REQ-012 reqN_readdata  output  WIDTH  read data, qualified by reqN_rvalid.
REQ-013 mem_address  output  ELEMENTS_W; mem_read  output  1; mem_write  output  1; mem_writedata  output  WIDTH; drive the single-port memory.
REQ-014 mem_readdata  input  WIDTH  memory registered read data (1-cycle latency).
REQ-015 init_done  output  1  memory clear sequence complete.

Function
REQ-016 SHALL implement states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-017 In INIT, every cycle: mem_write=1, mem_read=0, mem_address=counter, mem_writedata=0; counter increments.
REQ-018 When counter = ELEMENTS-1 in INIT, that cycle's write completes the sweep and next state is RUN; init_done=1 from the first RUN cycle onward.
REQ-019 In INIT, reqN_ready=0 for both requesters regardless of valid.
REQ-020 In RUN, at most one requester granted per cycle; reqN_ready is combinational from reqN_valid and the priority pointer.
REQ-021 Single valid requester SHALL be granted in the same cycle.
REQ-022 Both valid: requester named by priority pointer granted; pointer then points to the other requester.
REQ-023 Pointer SHALL change only on a cycle with a grant that had contention; no grant or single-requester grant leaves it unchanged.
REQ-024 Granted operation drives mem_address, mem_writedata from the winner; mem_write = winner write, mem_read = not winner write.
REQ-025 No grant: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
REQ-026 Accepted read: reqN_rvalid=1 exactly one cycle after acceptance, only for the accepting requester; reqN_readdata = mem_readdata.
REQ-027 Back-to-back accepted operations every cycle SHALL be supported with no bubbles.
REQ-028 Write then read of same address in following cycle SHALL return the newly written data.
REQ-029 Requesters SHALL NOT make valid depend on ready; arbiter holds no request state beyond the accepted cycle.

Reset
REQ-030 rst_n low asynchronously: state=INIT, counter=0, pointer=0, init_done=0, both rvalid=0, both ready=0.
REQ-031 Reset mid-INIT or mid-RUN restarts the full clear sweep from address 0; any pending rvalid is dropped.

Structure
REQ-032 State encoding localparams (INIT, RUN) SHALL live in the shared armleocpu defines package; no other shared typedefs.
REQ-033 Two-way round-robin grant logic SHALL be sub-module armleocpu_rr_arb2 (inputs valid[1:0], pointer; outputs grant[1:0]).
REQ-034 Memory instance (armleocpu_mem_1rw-compatible) SHALL sit outside this block.

Verification (ELEMENTS_W=3, WIDTH=32, memory model attached)
REQ-035 Reset release, both valid -> 8 INIT cycles writing 0 to addresses 0..7, ready=0 throughout, init_done=1 on cycle 9.
REQ-036 RUN, req0 write addr 5 = 0xDEADBEEF, next cycle req0 read addr 5 -> req0_rvalid=1 one cycle later with 0xDEADBEEF, req1_rvalid=0.
REQ-037 Both valid continuously, reads to addr 1 (req0) and 2 (req1) -> grants alternate 0,1,0,1; each rvalid follows its grant by one cycle.
REQ-038 Only req1 valid for 4 cycles, pointer=1 -> req1 granted all 4, pointer stays 1; then both valid -> req1 granted first.
REQ-039 rst_n asserted mid-RUN with read in flight -> rvalid=0 immediately, init_done=0, sweep restarts at address 0.
REQ-040 Read of never-written address after init -> readdata 0x00000000.
